// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the multiplier/accumulator pair: FSM states,
// field constants and an operand unpack helper.
package fpu_pkg;

    typedef enum logic [2:0] {
        WAIT_IN,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        COUNT,
        DRIVE_S
    } state_t;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_MAX    = 128;
    localparam int EXP_DENORM = -126;

    localparam int EXP_W = 10;
    localparam int MAN_W = 27;

    localparam logic signed [EXP_W-1:0] EXP_MIN_E = EXP_W'(EXP_DENORM);
    localparam logic signed [EXP_W-1:0] EXP_MAX_E = EXP_W'(EXP_MAX);

    localparam logic [31:0] FP_NAN     = 32'hFFC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [MAN_W-1:0]        man;
    } unpacked_t;

    // Mantissa layout: hidden bit, 23 fraction bits, guard, round, sticky.
    function automatic unpacked_t fp_unpack(input logic [31:0] f);
        unpacked_t u;
        u.sign = f[31];
        if (f[30:23] == 8'd0) begin
            u.exp = EXP_MIN_E;
            u.man = {1'b0, f[22:0], 3'b000};
        end else begin
            u.exp = EXP_W'(int'(f[30:23]) - EXP_BIAS);
            u.man = {1'b1, f[22:0], 3'b000};
        end
        return u;
    endfunction

endpackage

// File: rtl/fpu_align_shifter.sv
// Combinational 27-bit logarithmic right shifter; every bit shifted out is
// ORed into the result's sticky (lsb) position.
module fpu_align_shifter (
    input  logic [26:0] din,
    input  logic [4:0]  shift,
    output logic [26:0] dout
);
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            logic [26:0] src;
            logic [26:0] q;
            logic        src_lost;
            logic        q_lost;
            if (gi == 0) begin : g_first
                assign src      = din;
                assign src_lost = 1'b0;
            end else begin : g_next
                assign src      = g_stage[gi-1].q;
                assign src_lost = g_stage[gi-1].q_lost;
            end
            assign q      = shift[gi] ? (src >> SH) : src;
            assign q_lost = src_lost | (shift[gi] & (|src[SH-1:0]));
        end
    endgenerate

    assign dout = {g_stage[4].q[26:1], g_stage[4].q[0] | g_stage[4].q_lost};

endmodule

// File: rtl/fpu_accumulator.sv
// Multi-cycle FP32 accumulator: sums N_TERMS products from a req/ack stream
// starting at +0.0 and hands the result downstream over the same handshake.
module fpu_accumulator
    import fpu_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_z,
    input  logic        in_z_req,
    output logic        in_z_ack,
    output logic [31:0] out_s,
    output logic        out_s_req,
    input  logic        out_s_ack
);

    state_t state_reg, state_next;

    logic [31:0]             acc_reg, z_reg, out_s_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    in_z_ack_reg, out_s_req_reg;
    logic                    sign_a_reg, sign_b_reg, sum_sign_reg;
    logic signed [EXP_W-1:0] exp_a_reg, exp_b_reg, sum_exp_reg;
    logic [MAN_W-1:0]        man_a_reg, man_b_reg, sum_man_reg;

    logic in_xfer, out_xfer, last_term;
    assign in_xfer   = in_z_req && in_z_ack_reg;
    assign out_xfer  = out_s_req_reg && out_s_ack;
    assign last_term = (cnt_reg == CNT_W'(N_TERMS - 1));

    // Operand classification and special-case resolution
    unpacked_t acc_u, z_u;
    assign acc_u = fp_unpack(acc_reg);
    assign z_u   = fp_unpack(z_reg);

    logic acc_nan, acc_inf, acc_zero, z_nan, z_inf, z_zero;
    assign acc_nan  = (acc_reg[30:23] == 8'hFF) && (acc_reg[22:0] != 23'd0);
    assign acc_inf  = (acc_reg[30:23] == 8'hFF) && (acc_reg[22:0] == 23'd0);
    assign acc_zero = (acc_reg[30:0] == 31'd0);
    assign z_nan    = (z_reg[30:23] == 8'hFF) && (z_reg[22:0] != 23'd0);
    assign z_inf    = (z_reg[30:23] == 8'hFF) && (z_reg[22:0] == 23'd0);
    assign z_zero   = (z_reg[30:0] == 31'd0);

    logic        special;
    logic [31:0] special_val;
    always_comb begin
        special     = 1'b1;
        special_val = FP_NAN;
        if (acc_nan || z_nan)
            special_val = FP_NAN;
        else if (acc_inf && z_inf && (acc_reg[31] != z_reg[31]))
            special_val = FP_NAN;
        else if (acc_inf)
            special_val = acc_reg;
        else if (z_inf)
            special_val = z_reg;
        else if (acc_zero && z_zero)
            special_val = {acc_reg[31] & z_reg[31], 31'd0};
        else if (acc_zero)
            special_val = z_reg;
        else if (z_zero)
            special_val = acc_reg;
        else begin
            special     = 1'b0;
            special_val = acc_reg;
        end
    end

    // Alignment: the smaller-exponent mantissa is shifted, distance capped at 27
    logic             a_ge;
    logic [EXP_W-1:0] exp_diff;
    logic [4:0]       shamt;
    logic [MAN_W-1:0] shift_in, shift_out;
    assign a_ge     = (exp_a_reg >= exp_b_reg);
    assign exp_diff = a_ge ? (exp_a_reg - exp_b_reg) : (exp_b_reg - exp_a_reg);
    assign shamt    = (exp_diff > 10'd27) ? 5'd27 : exp_diff[4:0];
    assign shift_in = a_ge ? man_b_reg : man_a_reg;

    fpu_align_shifter u_shifter (
        .din   (shift_in),
        .shift (shamt),
        .dout  (shift_out)
    );

    logic [27:0] add_sum;
    logic        add_sign;
    always_comb begin
        add_sum  = 28'd0;
        add_sign = sign_a_reg;
        if (sign_a_reg == sign_b_reg) begin
            add_sum = {1'b0, man_a_reg} + {1'b0, man_b_reg};
        end else if (man_a_reg >= man_b_reg) begin
            add_sum = {1'b0, man_a_reg} - {1'b0, man_b_reg};
        end else begin
            add_sum  = {1'b0, man_b_reg} - {1'b0, man_a_reg};
            add_sign = sign_b_reg;
        end
    end

    logic norm_done;
    assign norm_done = sum_man_reg[MAN_W-1] || (sum_exp_reg <= EXP_MIN_E) ||
                       (sum_man_reg == '0);

    // Round to nearest even on guard/round/sticky, then pack
    logic                    round_up;
    logic [24:0]             rnd;
    logic [23:0]             rnd_man;
    logic signed [EXP_W-1:0] rnd_exp;
    logic [7:0]              rnd_field;
    logic [31:0]             rnd_word;
    always_comb begin
        round_up = sum_man_reg[2] & (sum_man_reg[1] | sum_man_reg[0] | sum_man_reg[3]);
        rnd      = {1'b0, sum_man_reg[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            rnd_man = rnd[24:1];
            rnd_exp = sum_exp_reg + 10'sd1;
        end else begin
            rnd_man = rnd[23:0];
            rnd_exp = sum_exp_reg;
        end
        rnd_field = rnd_exp[7:0] + 8'(EXP_BIAS);
        if (rnd_exp >= EXP_MAX_E)
            rnd_word = FP_POS_INF | {sum_sign_reg, 31'd0};
        else if (!rnd_man[23])
            rnd_word = {sum_sign_reg, 8'd0, rnd_man[22:0]};
        else
            rnd_word = {sum_sign_reg, rnd_field, rnd_man[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= WAIT_IN;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_IN: if (in_xfer) state_next = UNPACK;
            UNPACK:  state_next = special ? COUNT : ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    if (norm_done) state_next = ROUND;
            ROUND:   state_next = COUNT;
            COUNT:   state_next = last_term ? DRIVE_S : WAIT_IN;
            DRIVE_S: if (out_xfer) state_next = WAIT_IN;
            default: state_next = WAIT_IN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg       <= '0;
            z_reg         <= '0;
            out_s_reg     <= '0;
            cnt_reg       <= '0;
            in_z_ack_reg  <= 1'b0;
            out_s_req_reg <= 1'b0;
            sign_a_reg    <= 1'b0;
            sign_b_reg    <= 1'b0;
            sum_sign_reg  <= 1'b0;
            exp_a_reg     <= '0;
            exp_b_reg     <= '0;
            sum_exp_reg   <= '0;
            man_a_reg     <= '0;
            man_b_reg     <= '0;
            sum_man_reg   <= '0;
        end else begin
            in_z_ack_reg  <= (state_reg == WAIT_IN) && !in_xfer;
            out_s_req_reg <= (state_reg == DRIVE_S) && !out_xfer;
            case (state_reg)
                WAIT_IN: if (in_xfer) z_reg <= in_z;
                UNPACK: begin
                    if (special) acc_reg <= special_val;
                    sign_a_reg <= acc_u.sign;
                    exp_a_reg  <= acc_u.exp;
                    man_a_reg  <= acc_u.man;
                    sign_b_reg <= z_u.sign;
                    exp_b_reg  <= z_u.exp;
                    man_b_reg  <= z_u.man;
                end
                ALIGN: begin
                    if (a_ge) begin
                        man_b_reg <= shift_out;
                    end else begin
                        man_a_reg <= shift_out;
                        exp_a_reg <= exp_b_reg;
                    end
                end
                ADD: begin
                    sum_sign_reg <= (add_sum == 28'd0) ? 1'b0 : add_sign;
                    if (add_sum[27]) begin
                        sum_man_reg <= {add_sum[27:2], add_sum[1] | add_sum[0]};
                        sum_exp_reg <= exp_a_reg + 10'sd1;
                    end else begin
                        sum_man_reg <= add_sum[26:0];
                        sum_exp_reg <= exp_a_reg;
                    end
                end
                NORM: begin
                    if (!norm_done) begin
                        sum_man_reg <= sum_man_reg << 1;
                        sum_exp_reg <= sum_exp_reg - 10'sd1;
                    end
                end
                ROUND: acc_reg <= rnd_word;
                COUNT: begin
                    if (last_term) begin
                        cnt_reg   <= '0;
                        out_s_reg <= acc_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DRIVE_S: if (out_xfer) acc_reg <= '0;
                default: ;
            endcase
        end
    end

    assign in_z_ack  = in_z_ack_reg;
    assign out_s_req = out_s_req_reg;
    assign out_s     = out_s_reg;

endmodule

// File: tb/tb_fpu_accumulator.sv
// Scoreboard bench for fpu_accumulator: directed sums plus random terms checked
// against an exact-arithmetic FP32 reference.
module tb_fpu_accumulator;

    localparam int N_TERMS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_z;
    logic        in_z_req;
    logic        in_z_ack;
    logic [31:0] out_s;
    logic        out_s_req;
    logic        out_s_ack;

    int total = 0;
    int bad   = 0;
    int sum_n = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_acc = 32'd0;
    int          model_cnt = 0;
    int          ack_mode  = 0;   // 0: always ready, 1: random, 2: hold off

    fpu_accumulator #(.N_TERMS(N_TERMS), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_z      (in_z),
        .in_z_req  (in_z_req),
        .in_z_ack  (in_z_ack),
        .out_s     (out_s),
        .out_s_req (out_s_req),
        .out_s_ack (out_s_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Place a finite FP32 value as an integer multiple of 2^-149.
    function automatic logic [299:0] place(input logic [31:0] f);
        logic [299:0] v;
        v = 300'({(f[30:23] != 8'd0), f[22:0]});
        if (f[30:23] != 8'd0) v = v << (int'(f[30:23]) - 1);
        return v;
    endfunction

    // Exact sum followed by a single round-to-nearest-even step.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ma, mb, mag;
        logic         rs, half, sticky;
        logic [24:0]  m;
        int           p, l, fld;
        logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_zero = (b[30:0] == 0);
        if (a_nan || b_nan) return 32'hFFC00000;
        if (a_inf && b_inf && (a[31] != b[31])) return 32'hFFC00000;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
        if (a_zero) return b;
        if (b_zero) return a;
        ma = place(a);
        mb = place(b);
        if (a[31] == b[31]) begin
            mag = ma + mb; rs = a[31];
        end else if (ma >= mb) begin
            mag = ma - mb; rs = a[31];
        end else begin
            mag = mb - ma; rs = b[31];
        end
        if (mag == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {rs, 8'd0, mag[22:0]};
        l      = p - 23;
        m      = 25'(mag >> l);
        half   = (l > 0) ? mag[l-1] : 1'b0;
        sticky = 1'b0;
        for (int i = 0; i < l - 1; i++) sticky |= mag[i];
        if (half && (sticky || m[0])) m = m + 25'd1;
        fld = p - 22;
        if (m[24]) begin
            m = m >> 1;
            fld++;
        end
        if (fld >= 255) return {rs, 8'hFF, 23'd0};
        return {rs, 8'(fld), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int k;
        k = $urandom_range(0, 99);
        if (k < 3)  return {1'($urandom_range(0, 1)), 31'd0};
        if (k < 5)  return {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
        if (k < 6)  return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
        if (k < 10) return {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
        if (k < 13) return {1'($urandom_range(0, 1)), 8'hFE, 23'($urandom)};
        if (k < 25) return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // Present one term and hold it until the accumulator takes it.
    task automatic send_term(input logic [31:0] z);
        int waited;
        waited = 0;
        @(posedge clk);
        #1;
        in_z     = z;
        in_z_req = 1'b1;
        @(negedge clk);
        while (!in_z_ack && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!in_z_ack) begin
            bad++;
            $display("FAIL in_ack_timeout got=%b want=1", in_z_ack);
            in_z_req = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_z_req = 1'b0;
        end
    endtask

    task automatic model_term(input logic [31:0] z);
        model_acc = ref_add(model_acc, z);
        model_cnt++;
        if (model_cnt == N_TERMS) begin
            exp_q.push_back(model_acc);
            model_acc = 32'd0;
            model_cnt = 0;
        end
    endtask

    task automatic directed(input logic [31:0] t0, input logic [31:0] t1,
                            input logic [31:0] t2, input logic [31:0] t3,
                            input logic [31:0] want);
        exp_q.push_back(want);
        send_term(t0);
        send_term(t1);
        send_term(t2);
        send_term(t3);
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
        end
    endtask

    // Consumer side: drives out_s_ack according to ack_mode.
    initial begin
        out_s_ack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                1:       out_s_ack = 1'($urandom_range(0, 1));
                2:       out_s_ack = 1'b0;
                default: out_s_ack = 1'b1;
            endcase
        end
    end

    // Monitor: a sum is delivered on the next edge when req and ack are both high.
    always @(negedge clk) begin
        logic [31:0] want;
        if (!rst && out_s_req && out_s_ack) begin
            sum_n++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sum_unexpected got=%h want=none", out_s);
            end else begin
                want = exp_q.pop_front();
                $display("sum %0d: out_s=%h expected=%h", sum_n, out_s, want);
                check("sum", out_s, want);
            end
        end
    end

    initial begin
        int waited;
        rst      = 1'b1;
        in_z     = 32'd0;
        in_z_req = 1'b0;
        #2;
        check("rst_in_z_ack", {31'd0, in_z_ack}, 32'd0);
        check("rst_out_s_req", {31'd0, out_s_req}, 32'd0);
        check("rst_out_s", out_s, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        directed(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);
        directed(32'h3FC00000, 32'hBFC00000, 32'h80000000, 32'h80000000, 32'h00000000);
        directed(32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h3F800000, 32'hFFC00000);
        directed(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000, 32'h7F800000);
        directed(32'h3F800000, 32'h33800000, 32'h00000000, 32'h00000000, 32'h3F800000);
        directed(32'h3F800000, 32'h33800001, 32'h00000000, 32'h00000000, 32'h3F800001);
        wait_drain();

        // Backpressure: result held while the consumer withholds ack.
        ack_mode = 2;
        @(posedge clk);
        #2;
        directed(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000);
        waited = 0;
        @(negedge clk);
        while (!out_s_req && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        for (int c = 0; c < 10; c++) begin
            check("hold_out_s_req", {31'd0, out_s_req}, 32'd1);
            check("hold_out_s", out_s, 32'h40800000);
            check("hold_in_z_ack", {31'd0, in_z_ack}, 32'd0);
            @(negedge clk);
        end
        ack_mode = 0;
        directed(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);
        wait_drain();

        // Asynchronous reset after two accepted terms discards them.
        send_term(32'h47000000);
        send_term(32'h47000000);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_in_z_ack", {31'd0, in_z_ack}, 32'd0);
        check("mid_rst_out_s_req", {31'd0, out_s_req}, 32'd0);
        check("mid_rst_out_s", out_s, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        directed(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);
        wait_drain();

        // Random terms against the exact reference, with random consumer stalls.
        ack_mode = 1;
        for (int g = 0; g < 40 * N_TERMS; g++) begin
            logic [31:0] z;
            z = rand_fp();
            model_term(z);
            send_term(z);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        ack_mode = 0;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
